ex_stage: RTL and testbench

Execute stage of the multi-cycle RISC-V core used for the DNN workloads. It sits between decode and memory access:
- holds one decoded instruction in a stage register and drives the ALU operands and opcode from it;
- takes back the ALU's Result/Zero, resolves branches and jumps, and hands the write-back value downstream over a valid/ready handshake;
- keeps the instruction in the stage for extra cycles when the op is a multiply, so the ALU's combinational multiply output has time to settle.

---
 rtl/ex_stage.sv | 216 +++++++++++++++++++++
 tb/tb_ex_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the multi-cycle RISC-V core.
// Holds one decoded instruction, feeds the external ALU from it, resolves
// branches/jumps, and hands the write-back value to the memory stage over a
// valid/ready handshake. Multiplies are held for MUL_LAT cycles so the
// ALU's combinational multiplier output has time to settle.
module ex_stage #(
  parameter int unsigned MUL_LAT = 2  // cycles a mul occupies the stage, 1..7
) (
  input  logic        clk,
  input  logic        resetn,

  // decode side
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic [31:0] in_imm,
  input  logic [2:0]  in_alu_op,
  input  logic        in_a_pc,
  input  logic        in_b_imm,
  input  logic [4:0]  in_rd,
  input  logic        in_rf_wen,
  input  logic        in_branch,
  input  logic [2:0]  in_funct3,
  input  logic        in_jal,
  input  logic        in_jalr,

  // ALU side
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,

  // memory stage side
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_rf_wen,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  // ALU opcodes used by the stage itself
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;
  localparam logic [2:0] OP_SLTU = 3'b011;

  // Initial WAIT count; a MUL_LAT of 1 means mul behaves like any other op.
  localparam logic [2:0] MUL_CNT   = 3'(MUL_LAT - 1);
  localparam bit         MUL_MULTI = (MUL_LAT > 1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_WAIT  = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Everything captured from decode on accept.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [2:0]  alu_op;
    logic        a_pc;
    logic        b_imm;
    logic [4:0]  rd;
    logic        rf_wen;
    logic        branch;
    logic [2:0]  funct3;
    logic        jal;
    logic        jalr;
  } instr_t;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  instr_t      instr_q, instr_d;
  instr_t      instr_in;

  logic        accept;
  logic        in_is_mul;
  logic        taken;
  logic        is_jump;
  logic [31:0] target_base;
  logic [31:0] target_sum;
  logic [31:0] link_pc;

  // Bundle the incoming decode fields into one record.
  always_comb begin
    instr_in        = '0;
    instr_in.pc     = in_pc;
    instr_in.rs1    = in_rs1;
    instr_in.rs2    = in_rs2;
    instr_in.imm    = in_imm;
    instr_in.alu_op = in_alu_op;
    instr_in.a_pc   = in_a_pc;
    instr_in.b_imm  = in_b_imm;
    instr_in.rd     = in_rd;
    instr_in.rf_wen = in_rf_wen;
    instr_in.branch = in_branch;
    instr_in.funct3 = in_funct3;
    instr_in.jal    = in_jal;
    instr_in.jalr   = in_jalr;
  end

  // Operand and opcode selection; branches always compare rs1 against rs2.
  always_comb begin
    alu_a  = instr_q.a_pc  ? instr_q.pc  : instr_q.rs1;
    alu_b  = instr_q.b_imm ? instr_q.imm : instr_q.rs2;
    alu_op = instr_q.alu_op;
    if (instr_q.branch) begin
      alu_a = instr_q.rs1;
      alu_b = instr_q.rs2;
      if (!instr_q.funct3[2]) begin
        alu_op = OP_SUB;             // beq / bne: equality via zero flag
      end else if (!instr_q.funct3[1]) begin
        alu_op = OP_SLT;             // blt / bge
      end else begin
        alu_op = OP_SLTU;            // bltu / bgeu
      end
    end
  end

  // Branch resolution and the dedicated control-transfer adder.
  always_comb begin
    // funct3[2] flips the sense for slt-style compares (result 1 => zero=0);
    // funct3[0] selects the negated variant (bne/bge/bgeu).
    taken       = alu_zero ^ instr_q.funct3[0] ^ instr_q.funct3[2];
    is_jump     = instr_q.jal || instr_q.jalr;
    target_base = instr_q.jalr ? instr_q.rs1 : instr_q.pc;
    target_sum  = target_base + instr_q.imm;
    link_pc     = instr_q.pc + 32'd4;
  end

  // Downstream-facing values, all derived from the stage register.
  always_comb begin
    out_valid   = (state_q == S_DONE);
    out_result  = is_jump ? link_pc : alu_result;
    out_rd      = instr_q.rd;
    out_rf_wen  = instr_q.rf_wen && !instr_q.branch;
    redirect    = out_valid && (is_jump || (instr_q.branch && taken));
    redirect_pc = {target_sum[31:1], target_sum[0] & ~instr_q.jalr};
    // Blocking intake on a redirect handoff keeps the wrong-path
    // instruction offered in that same cycle out of the stage.
    in_ready    = (state_q == S_EMPTY) ||
                  ((state_q == S_DONE) && out_ready && !redirect);
  end

  // Intake decision for the instruction currently offered by decode.
  always_comb begin
    accept    = in_valid && in_ready;
    in_is_mul = MUL_MULTI && (in_alu_op == OP_MUL) && !in_branch;
  end

  // Next-state logic for the stage FSM, counter and stage register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;

    case (state_q)
      S_EMPTY: begin
        state_d = S_EMPTY;
      end
      S_WAIT: begin
        // The last WAIT cycle is the one where the count is 1; the next
        // edge shows out_valid, giving MUL_LAT cycles from accept.
        if (cnt_q <= 3'd1) begin
          state_d = S_DONE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_EMPTY;
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase

    // A new instruction can only arrive from EMPTY or a completing DONE,
    // so it simply overrides the drain decision above.
    if (accept) begin
      instr_d = instr_in;
      if (in_is_mul) begin
        state_d = S_WAIT;
        cnt_d   = MUL_CNT;
      end else begin
        state_d = S_DONE;
        cnt_d   = 3'd0;
      end
    end
  end

  // Stage state; reset drops any in-flight instruction immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_EMPTY;
      cnt_q   <= 3'd0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: table of single-instruction vectors plus hand-written
// sequences for back-to-back issue, mul latency, stalls and reset.
module tb_ex_stage;

  localparam int MUL_LAT = 2;

  logic        clk;
  logic        resetn;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_rs1, in_rs2, in_imm;
  logic [2:0]  in_alu_op;
  logic        in_a_pc, in_b_imm;
  logic [4:0]  in_rd;
  logic        in_rf_wen, in_branch;
  logic [2:0]  in_funct3;
  logic        in_jal, in_jalr;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_rf_wen;
  logic        redirect;
  logic [31:0] redirect_pc;

  int n_pass;
  int n_total;

  ex_stage #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_alu_op(in_alu_op), .in_a_pc(in_a_pc), .in_b_imm(in_b_imm),
    .in_rd(in_rd), .in_rf_wen(in_rf_wen), .in_branch(in_branch),
    .in_funct3(in_funct3), .in_jal(in_jal), .in_jalr(in_jalr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_rf_wen(out_rf_wen),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU the stage talks to.
  always_comb begin
    case (alu_op)
      3'b000:  alu_result = alu_a & alu_b;
      3'b001:  alu_result = alu_a | alu_b;
      3'b010:  alu_result = alu_a + alu_b;
      3'b011:  alu_result = {31'b0, alu_a < alu_b};
      3'b100:  alu_result = alu_a ^ alu_b;
      3'b101:  alu_result = alu_a * alu_b;
      3'b110:  alu_result = alu_a - alu_b;
      default: alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  typedef struct {
    logic [2:0]  op;
    logic        a_pc, b_imm;
    logic [31:0] pc, rs1, rs2, imm;
    logic        branch;
    logic [2:0]  f3;
    logic        jal, jalr, rf_wen;
    logic [31:0] ea, eb;
    logic [2:0]  eop;
    logic [31:0] eres;
    logic        erfw, eredir;
    logic [31:0] erpc;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic [2:0] op, input logic a_pc, input logic b_imm,
    input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
    input logic [31:0] imm, input logic branch, input logic [2:0] f3,
    input logic jal, input logic jalr, input logic rf_wen,
    input logic [31:0] ea, input logic [31:0] eb, input logic [2:0] eop,
    input logic [31:0] eres, input logic erfw, input logic eredir,
    input logic [31:0] erpc);
    vec_t v;
    v.op = op; v.a_pc = a_pc; v.b_imm = b_imm;
    v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
    v.branch = branch; v.f3 = f3; v.jal = jal; v.jalr = jalr;
    v.rf_wen = rf_wen; v.ea = ea; v.eb = eb; v.eop = eop; v.eres = eres;
    v.erfw = erfw; v.eredir = eredir; v.erpc = erpc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v, input logic [4:0] rd);
    in_alu_op = v.op;  in_a_pc = v.a_pc;  in_b_imm = v.b_imm;
    in_pc = v.pc;  in_rs1 = v.rs1;  in_rs2 = v.rs2;  in_imm = v.imm;
    in_branch = v.branch;  in_funct3 = v.f3;
    in_jal = v.jal;  in_jalr = v.jalr;
    in_rf_wen = v.rf_wen;  in_rd = rd;
  endtask

  // Shorthand for plain register-register ALU ops in hand sequences.
  function automatic vec_t rr(input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b);
    return mk(op, 1'b0, 1'b0, 32'h0, a, b, 32'h0, 1'b0, 3'b000, 1'b0, 1'b0,
              1'b1, 32'h0, 32'h0, 3'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_pass = 0;
    n_total = 0;

    //        op     apc   bimm  pc            rs1           rs2           imm           br    f3      jal   jalr  wen   ea            eb            eop     eres          erfw  redir erpc
    vecs[0]  = mk(3'b000, 1'b0, 1'b0, 32'h0,        32'h0000F0F0, 32'h0000FF00, 32'h0,        1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 32'h0000F0F0, 32'h0000FF00, 3'b000, 32'h0000F000, 1'b1, 1'b0, 32'h0);
    vecs[1]  = mk(3'b001, 1'b0, 1'b0, 32'h0,        32'h0F,       32'hF0,       32'h0,        1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 32'h0F,       32'hF0,       3'b001, 32'hFF,       1'b1, 1'b0, 32'h0);
    vecs[2]  = mk(3'b010, 1'b0, 1'b0, 32'h0,        32'd5,        32'd7,        32'h0,        1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 32'd5,        32'd7,        3'b010, 32'd12,       1'b1, 1'b0, 32'h0);
    vecs[3]  = mk(3'b011, 1'b0, 1'b0, 32'h0,        32'd1,        32'hFFFFFFFF, 32'h0,        1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 32'd1,        32'hFFFFFFFF, 3'b011, 32'd1,        1'b1, 1'b0, 32'h0);
    vecs[4]  = mk(3'b100, 1'b0, 1'b0, 32'h0,        32'hFF,       32'h0F,       32'h0,        1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 32'hFF,       32'h0F,       3'b100, 32'hF0,       1'b1, 1'b0, 32'h0);
    vecs[5]  = mk(3'b110, 1'b0, 1'b0, 32'h0,        32'd3,        32'd5,        32'h0,        1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 32'd3,        32'd5,        3'b110, 32'hFFFFFFFE, 1'b1, 1'b0, 32'h0);
    vecs[6]  = mk(3'b111, 1'b0, 1'b0, 32'h0,        32'hFFFFFFFF, 32'd1,        32'h0,        1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1,        3'b111, 32'd1,        1'b1, 1'b0, 32'h0);
    vecs[7]  = mk(3'b010, 1'b1, 1'b1, 32'h1000,     32'hDEAD,     32'hBEEF,     32'h10,       1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 32'h1000,     32'h10,       3'b010, 32'h1010,     1'b1, 1'b0, 32'h0);
    // Branches carry a mul ALUop to show they never enter WAIT.
    vecs[8]  = mk(3'b101, 1'b1, 1'b1, 32'h40,       32'd9,        32'd9,        32'hFFFFFFF0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 32'd9,        32'd9,        3'b110, 32'd0,        1'b0, 1'b1, 32'h30);
    vecs[9]  = mk(3'b101, 1'b1, 1'b1, 32'h40,       32'd9,        32'd9,        32'hFFFFFFF0, 1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 32'd9,        32'd9,        3'b110, 32'd0,        1'b0, 1'b0, 32'h30);
    vecs[10] = mk(3'b101, 1'b0, 1'b0, 32'h100,      32'hFFFFFFFF, 32'd1,        32'h20,       1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,        3'b111, 32'd1,        1'b0, 1'b1, 32'h120);
    vecs[11] = mk(3'b101, 1'b0, 1'b0, 32'h100,      32'hFFFFFFFF, 32'd1,        32'h20,       1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,        3'b011, 32'd0,        1'b0, 1'b1, 32'h120);
    vecs[12] = mk(3'b101, 1'b0, 1'b0, 32'h100,      32'hFFFFFFFF, 32'd1,        32'h20,       1'b1, 3'b101, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,        3'b111, 32'd1,        1'b0, 1'b0, 32'h120);
    vecs[13] = mk(3'b101, 1'b0, 1'b0, 32'h100,      32'hFFFFFFFF, 32'd1,        32'h20,       1'b1, 3'b110, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,        3'b011, 32'd0,        1'b0, 1'b0, 32'h120);
    vecs[14] = mk(3'b010, 1'b1, 1'b1, 32'h300,      32'h0,        32'h0,        32'h40,       1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 32'h300,      32'h40,       3'b010, 32'h304,      1'b1, 1'b1, 32'h340);
    vecs[15] = mk(3'b010, 1'b0, 1'b1, 32'h200,      32'h1001,     32'h0,        32'h4,        1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 32'h1001,     32'h4,        3'b010, 32'h204,      1'b1, 1'b1, 32'h1004);
    vecs[16] = mk(3'b010, 1'b1, 1'b1, 32'hFFFFFFF0, 32'h0,        32'h0,        32'h20,       1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 32'hFFFFFFF0, 32'h20,       3'b010, 32'hFFFFFFF4, 1'b1, 1'b1, 32'h10);

    // Reset
    resetn = 1'b0;  in_valid = 1'b0;  out_ready = 1'b1;
    drive(rr(3'b000, 32'h0, 32'h0), 5'd0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst redirect", 32'(redirect), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_rd", 32'(out_rd), 32'd0);
    check("rst out_rf_wen", 32'(out_rf_wen), 32'd0);
    check("rst alu_a", alu_a, 32'd0);
    $display("txn reset: out_valid=%0d in_ready=%0d", out_valid, in_ready);

    // Table-driven single instructions, out_ready held high
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i], 5'(i + 1));
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("v%0d alu_a", i), alu_a, vecs[i].ea);
      check($sformatf("v%0d alu_b", i), alu_b, vecs[i].eb);
      check($sformatf("v%0d alu_op", i), 32'(alu_op), 32'(vecs[i].eop));
      check($sformatf("v%0d result", i), out_result, vecs[i].eres);
      check($sformatf("v%0d rd", i), 32'(out_rd), 32'(i + 1));
      check($sformatf("v%0d rf_wen", i), 32'(out_rf_wen), 32'(vecs[i].erfw));
      check($sformatf("v%0d redirect", i), 32'(redirect), 32'(vecs[i].eredir));
      check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(!vecs[i].eredir));
      if (vecs[i].eredir)
        check($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].erpc);
      $display("txn v%0d: result=%0h redirect=%0d redirect_pc=%0h",
               i, out_result, redirect, redirect_pc);
      tick();
      check($sformatf("v%0d drained", i), 32'(out_valid), 32'd0);
    end

    // Back-to-back xor then sub
    drive(rr(3'b100, 32'hFF, 32'h0F), 5'd3);
    in_valid = 1'b1;
    tick();
    check("b2b xor result", out_result, 32'hF0);
    check("b2b xor in_ready", 32'(in_ready), 32'd1);
    $display("txn b2b xor: result=%0h", out_result);
    drive(rr(3'b110, 32'd3, 32'd5), 5'd4);
    tick();
    in_valid = 1'b0;
    check("b2b sub valid", 32'(out_valid), 32'd1);
    check("b2b sub result", out_result, 32'hFFFFFFFE);
    check("b2b sub rd", 32'(out_rd), 32'd4);
    $display("txn b2b sub: result=%0h", out_result);
    tick();
    check("b2b drained", 32'(out_valid), 32'd0);

    // mul 6 x 7 with MUL_LAT wait cycles
    drive(rr(3'b101, 32'd6, 32'd7), 5'd5);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k < MUL_LAT; k++) begin
      check($sformatf("mul wait%0d valid", k), 32'(out_valid), 32'd0);
      check($sformatf("mul wait%0d in_ready", k), 32'(in_ready), 32'd0);
      tick();
    end
    check("mul valid", 32'(out_valid), 32'd1);
    check("mul result", out_result, 32'd42);
    $display("txn mul: result=%0d", out_result);
    tick();
    check("mul drained", 32'(out_valid), 32'd0);

    // jalr held under downstream stall; wrong-path offer must be dropped
    out_ready = 1'b0;
    drive(vecs[15], 5'd6);
    in_valid = 1'b1;
    tick();
    drive(rr(3'b010, 32'd1, 32'd1), 5'd7);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall%0d valid", k), 32'(out_valid), 32'd1);
      check($sformatf("stall%0d result", k), out_result, 32'h204);
      check($sformatf("stall%0d redirect", k), 32'(redirect), 32'd1);
      check($sformatf("stall%0d redirect_pc", k), redirect_pc, 32'h1004);
      check($sformatf("stall%0d in_ready", k), 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("release result", out_result, 32'h204);
    check("release redirect_pc", redirect_pc, 32'h1004);
    check("release in_ready", 32'(in_ready), 32'd0);
    $display("txn jalr stall: result=%0h redirect_pc=%0h", out_result, redirect_pc);
    tick();
    in_valid = 1'b0;
    check("wrong path dropped", 32'(out_valid), 32'd0);
    tick();
    check("wrong path still empty", 32'(out_valid), 32'd0);

    // Reset during mul WAIT
    drive(rr(3'b101, 32'd6, 32'd7), 5'd9);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("rstmul in wait", 32'(out_valid), 32'd0);
    #2 resetn = 1'b0;
    #1;
    check("rstmul out_valid", 32'(out_valid), 32'd0);
    check("rstmul in_ready", 32'(in_ready), 32'd1);
    check("rstmul out_rd", 32'(out_rd), 32'd0);
    #1 resetn = 1'b1;
    tick();
    check("rstmul gone1", 32'(out_valid), 32'd0);
    tick();
    check("rstmul gone2", 32'(out_valid), 32'd0);
    check("rstmul ready", 32'(in_ready), 32'd1);
    $display("txn reset-in-wait: out_valid=%0d in_ready=%0d", out_valid, in_ready);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
